// File: rtl/izh_array.sv
// Time-multiplexed array of Izhikevich neurons sharing one fixed-point update datapath.
// A tick starts a sweep that updates one neuron per cycle and reports the new membrane value.
module izh_array #(
  parameter int N_NEURONS = 4,
  parameter int DW        = 16,
  parameter int FRAC      = 7,
  parameter int IW        = 8,
  parameter int DT_SHIFT  = 0,
  localparam int IDW      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic [N_NEURONS*IW-1:0]   current,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_addr,
  input  logic signed [DW-1:0]      cfg_data,
  output logic                      busy,
  output logic                      done,
  output logic                      upd_valid,
  output logic [IDW-1:0]            upd_id,
  output logic signed [DW-1:0]      upd_v,
  output logic                      spike
);

  localparam int AW = 2*DW + 16;
  typedef logic signed [AW-1:0] wide_t;

  localparam wide_t VMAX  = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam wide_t VMIN  = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam wide_t VPEAK = wide_t'(30 * (1 << FRAC));
  localparam wide_t K41   = wide_t'(41);
  localparam wide_t K5    = wide_t'(5);
  localparam wide_t K140S = wide_t'(140 * (1 << FRAC));

  localparam logic signed [DW-1:0] A_RST = DW'(3);
  localparam logic signed [DW-1:0] B_RST = DW'(26);
  localparam logic signed [DW-1:0] C_RST = DW'(-65 * (1 << FRAC));
  localparam logic signed [DW-1:0] D_RST = DW'(8 * (1 << FRAC));
  localparam logic signed [DW-1:0] U_RST = DW'(-1690);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic signed [DW-1:0] sat(input wide_t x);
    if (x > VMAX)      return VMAX[DW-1:0];
    else if (x < VMIN) return VMIN[DW-1:0];
    else               return x[DW-1:0];
  endfunction

  state_t                 state;
  logic [IDW-1:0]         idx;
  logic signed [DW-1:0]   pa, pb, pc, pd;
  logic signed [DW-1:0]   v_mem [N_NEURONS];
  logic signed [DW-1:0]   u_mem [N_NEURONS];

  logic signed [IW-1:0]   i_cur;
  logic signed [DW-1:0]   v_next, u_next;
  logic                   fire;
  wide_t                  v_w, u_w, i_w, vv, dv, bv, du, v_new_w, u_new_w, ud_w;

  // update datapath for the neuron selected by idx
  always_comb begin
    i_cur   = current[idx*IW +: IW];
    v_w     = wide_t'(v_mem[idx]);
    u_w     = wide_t'(u_mem[idx]);
    i_w     = wide_t'(i_cur);
    vv      = (v_w * v_w) >>> FRAC;
    dv      = ((vv * K41) >>> 10) + K5 * v_w + K140S - u_w + (i_w <<< FRAC);
    v_new_w = v_w + (dv >>> DT_SHIFT);
    bv      = (wide_t'(pb) * v_w) >>> FRAC;
    du      = (wide_t'(pa) * (bv - u_w)) >>> FRAC;
    u_new_w = u_w + (du >>> DT_SHIFT);
    ud_w    = u_w + wide_t'(pd);
    fire    = (v_w >= VPEAK);
    v_next  = fire ? pc : sat(v_new_w);
    u_next  = fire ? sat(ud_w) : sat(u_new_w);
  end

  // sweep control, state write-back and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      upd_valid <= 1'b0;
      spike     <= 1'b0;
      upd_id    <= '0;
      upd_v     <= '0;
      pa        <= A_RST;
      pb        <= B_RST;
      pc        <= C_RST;
      pd        <= D_RST;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem[k] <= C_RST;
        u_mem[k] <= U_RST;
      end
    end else begin
      done      <= 1'b0;
      upd_valid <= 1'b0;
      spike     <= 1'b0;
      if (cfg_we) begin
        case (cfg_addr)
          2'd0:    pa <= cfg_data;
          2'd1:    pb <= cfg_data;
          2'd2:    pc <= cfg_data;
          default: pd <= cfg_data;
        endcase
      end
      case (state)
        IDLE: begin
          // done is still high in the cycle right after DONE, so that tick is dropped
          if (tick && !done) begin
            state <= RUN;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          v_mem[idx] <= v_next;
          u_mem[idx] <= u_next;
          upd_valid  <= 1'b1;
          upd_id     <= idx;
          upd_v      <= v_next;
          spike      <= fire;
          if (idx == IDW'(N_NEURONS-1)) state <= DONE;
          else                          idx   <= idx + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          idx   <= '0;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_izh_array.sv
// Scoreboard bench for izh_array: an independent neuron model predicts every update.
module tb_izh_array;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int IW = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 tick = 1'b0;
  logic [N*IW-1:0]      current = '0;
  logic                 cfg_we = 1'b0;
  logic [1:0]           cfg_addr = 2'd0;
  logic signed [DW-1:0] cfg_data = '0;
  logic                 busy, done, upd_valid, spike;
  logic [1:0]           upd_id;
  logic signed [DW-1:0] upd_v;

  logic                 tick2 = 1'b0;
  logic [N*IW-1:0]      current2 = {4{8'd127}};
  logic                 busy2, done2, upd_valid2, spike2;
  logic [1:0]           upd_id2;
  logic signed [DW-1:0] upd_v2;

  always #5 clk = ~clk;

  izh_array #(.N_NEURONS(N), .DW(DW), .FRAC(7), .IW(IW), .DT_SHIFT(0)) dut (
    .clk(clk), .reset(reset), .tick(tick), .current(current),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .busy(busy), .done(done), .upd_valid(upd_valid), .upd_id(upd_id),
    .upd_v(upd_v), .spike(spike)
  );

  izh_array #(.N_NEURONS(N), .DW(DW), .FRAC(7), .IW(IW), .DT_SHIFT(1)) dut_dt (
    .clk(clk), .reset(reset), .tick(tick2), .current(current2),
    .cfg_we(1'b0), .cfg_addr(2'd0), .cfg_data(16'sd0),
    .busy(busy2), .done(done2), .upd_valid(upd_valid2), .upd_id(upd_id2),
    .upd_v(upd_v2), .spike(spike2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {int id; int v; bit spk;} exp_t;
  exp_t sbq[$];
  bit   sb_on = 1'b1;
  int   upd_cnt = 0;
  int   done_cnt = 0;
  int   last_v[N];
  bit   last_spk[N];
  bit   prev_last = 1'b0;

  // reference model state (default build: FRAC=7, DT_SHIFT=0, 16-bit saturation)
  int mv[N], mu[N];
  int ma, mb, mc, md;

  function automatic longint clamp16(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  task automatic model_reset();
    ma = 3; mb = 26; mc = -8320; md = 1024;
    for (int k = 0; k < N; k++) begin
      mv[k] = -8320;
      mu[k] = -1690;
    end
  endtask

  task automatic model_step(input int k, input int ii, output int ev, output bit es);
    longint v, u, vv, dv, du;
    v = mv[k];
    u = mu[k];
    if (v >= 3840) begin
      mv[k] = mc;
      mu[k] = int'(clamp16(u + md));
      ev = mc;
      es = 1'b1;
    end else begin
      vv = (v * v) >>> 7;
      dv = ((vv * 41) >>> 10) + 5 * v + 17920 - u + ii * 128;
      du = (ma * (((mb * v) >>> 7) - u)) >>> 7;
      mv[k] = int'(clamp16(v + dv));
      mu[k] = int'(clamp16(u + du));
      ev = mv[k];
      es = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (upd_valid) begin
      upd_cnt++;
      last_v[upd_id]   = upd_v;
      last_spk[upd_id] = spike;
      if (sb_on) begin
        if (sbq.size() == 0) begin
          check_val("sb_underflow", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check_val("sb_id", upd_id, e.id);
          check_val("sb_v", upd_v, e.v);
          check_val("sb_spike", spike, e.spk);
        end
      end
    end
    if (done) begin
      done_cnt++;
      check_val("done_after_last", prev_last, 1);
    end
    prev_last = upd_valid && (upd_id == 2'd3);
  end

  task automatic push_sweep(input logic [N*IW-1:0] cur);
    int ev;
    bit es;
    exp_t e;
    for (int k = 0; k < N; k++) begin
      model_step(k, $signed(cur[k*IW +: IW]), ev, es);
      e.id = k; e.v = ev; e.spk = es;
      sbq.push_back(e);
    end
  endtask

  task automatic sweep(input logic [N*IW-1:0] cur, input int hold);
    current = cur;
    push_sweep(cur);
    upd_cnt = 0;
    done_cnt = 0;
    @(negedge clk);
    tick = 1'b1;
    repeat (hold) @(negedge clk);
    tick = 1'b0;
    for (int n = 0; n < 30 && done_cnt == 0; n++) begin
      @(negedge clk);
      #1;
    end
    check_val("sweep_done", done_cnt, 1);
    check_val("upd_count", upd_cnt, 4);
    check_val("sb_drained", sbq.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sbq.delete();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic signed [DW-1:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
    case (addr)
      2'd0:    ma = d;
      2'd1:    mb = d;
      2'd2:    mc = d;
      default: md = d;
    endcase
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_valid", upd_valid, 0);
    check_val("rst_v", upd_v, 0);
    reset = 1'b0;
    @(negedge clk);

    // half-step build: first neuron with I=127 from reset
    tick2 = 1'b1;
    @(negedge clk);
    tick2 = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (upd_valid2) break;
    end
    check_val("dt_seen", upd_valid2, 1);
    check_val("dt_id", upd_id2, 0);
    check_val("dt_v", upd_v2, -361);
    repeat (8) @(negedge clk);

    // reset asserted in the middle of a sweep
    sb_on = 1'b0;
    current = 32'h007F_0000;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    check_val("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_valid", upd_valid, 0);
    check_val("mid_rst_spike", spike, 0);
    check_val("mid_rst_id", upd_id, 0);
    check_val("mid_rst_v", upd_v, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    sbq.delete();
    @(negedge clk);
    sb_on = 1'b1;
    sweep('0, 1);
    for (int k = 0; k < N; k++) check_val("rst_sweep_v", last_v[k], -8657);

    // reset coinciding with a write to c: reset must win
    reset = 1'b1;
    cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 16'sd1234;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cfg_we = 1'b0;
    sbq.delete();
    model_reset();
    @(negedge clk);

    // strong drive on neuron 2
    sweep(32'h007F_0000, 1);
    check_val("drive_v2", last_v[2], 7599);
    check_val("drive_v0", last_v[0], -8657);
    sweep(32'h007F_0000, 1);
    check_val("drive_spk2", last_spk[2], 1);
    check_val("drive_reset_v2", last_v[2], -8320);
    check_val("drive_spk0", last_spk[0], 0);
    sweep('0, 1);
    check_val("drive_u_after_spike", last_v[2], -9681);

    // tick raised during the done pulse is dropped
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    upd_cnt = 0;
    repeat (8) @(negedge clk);
    check_val("tick_at_done", upd_cnt, 0);

    // extra ticks while busy
    sweep('0, 4);
    repeat (4) @(negedge clk);
    check_val("busy_tick_extra", upd_cnt, 4);

    // tick held high: back-to-back sweeps
    current = '0;
    push_sweep('0);
    push_sweep('0);
    upd_cnt = 0;
    done_cnt = 0;
    tick = 1'b1;
    for (int n = 0; n < 60 && done_cnt < 2; n++) begin
      @(negedge clk);
      #1;
    end
    tick = 1'b0;
    check_val("held_done", done_cnt, 2);
    check_val("held_upd", upd_cnt, 8);
    repeat (4) @(negedge clk);
    check_val("held_no_extra", upd_cnt, 8);
    check_val("held_idle", busy, 0);

    // programmable reset value c
    do_reset();
    cfg_write(2'd2, -16'sd6400);
    sweep(32'h0000_007F, 1);
    sweep('0, 1);
    check_val("cfg_spk0", last_spk[0], 1);
    check_val("cfg_v0", last_v[0], -6400);
    sweep('0, 1);
    check_val("cfg_next_v0", last_v[0], -7002);

    // saturation of v, no wrap
    do_reset();
    cfg_write(2'd2, -16'sd32000);
    sweep(32'h0000_007F, 1);
    sweep('0, 1);
    check_val("sat_reset_v0", last_v[0], -32000);
    sweep('0, 1);
    check_val("sat_clamp_v0", last_v[0], 32767);
    check_val("sat_clamp_spk0", last_spk[0], 0);
    sweep('0, 1);
    check_val("sat_spk0", last_spk[0], 1);
    check_val("sat_spk_v0", last_v[0], -32000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/izh_array.md
Name: izh_array

Overview:
- Time-multiplexed array of N Izhikevich neurons sharing one fixed-point update datapath.
- Per-neuron v/u state is held in internal registers. Shared a, b, c, d parameters are runtime-programmable.
- One simulation step (a "sweep") is started by a tick. Each cycle of the sweep updates one neuron, emits its new membrane value, and flags a spike when one occurs.

Parameters:
- N_NEURONS, 4, number of neurons (>=1); index width IDW = max(1, clog2(N_NEURONS)).
- DW, 16, signed width of v, u, a, b, c, d.
- FRAC, 7, fractional bits; scale S = 2^FRAC.
- IW, 8, signed width of each neuron's input current (integer mV/ms units).
- DT_SHIFT, 0, time step = 2^-DT_SHIFT ms; applied to both dv and du.

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- tick, input, 1, starts a sweep when idle.
- current, input, N_NEURONS*IW, flattened signed currents; neuron k uses bits [k*IW +: IW].
- cfg_we, input, 1, parameter write strobe.
- cfg_addr, input, 2, parameter select: 0=a, 1=b, 2=c, 3=d.
- cfg_data, input, DW, signed parameter value.
- busy, output, 1, high while a sweep is in progress.
- done, output, 1, one-cycle pulse after the last neuron of a sweep is updated.
- upd_valid, output, 1, one-cycle pulse per neuron update.
- upd_id, output, IDW, index of the updated neuron.
- upd_v, output, DW, new v of that neuron.
- spike, output, 1, one-cycle pulse, coincident with upd_valid, when that neuron fired.

Behaviour:
- Reset (async, any time, including mid-sweep): all neurons, parameters and outputs are forced as follows, and the FSM returns to IDLE.
  - Parameters: a=3 (0.02), b=26 (0.2), c=-65*S=-8320, d=8*S=1024.
  - Every neuron: v=-8320, u=-1690.
  - Outputs: busy=0, done=0, upd_valid=0, spike=0, upd_id=0, upd_v=0.
- FSM: IDLE -> RUN on tick; RUN stays for N_NEURONS cycles with idx 0..N_NEURONS-1; after idx=N_NEURONS-1 -> DONE; DONE lasts 1 cycle with done=1 -> IDLE.
  - busy=1 in RUN and DONE.
  - tick while busy is ignored (not queued).
  - A tick in the same cycle as the done pulse is ignored.
  - A tick in the cycle after done starts a new sweep.
- Per RUN cycle, neuron idx is updated and the outputs are registered, so upd_* appear 1 cycle after the idx cycle. upd_valid is asserted N_NEURONS times per sweep, with ids in order 0..N-1.
- Current is sampled in the cycle its neuron is processed.
- Spike rule: tested on the stored v before the update.
  - If v >= 30*S (3840): v <= c, u <= u + d, spike=1, upd_v=c.
- Otherwise, all arithmetic is signed, with intermediates of at least 2*DW+8 bits and >>> as arithmetic (floor) shift:
  - vv = (v*v) >>> FRAC
  - dv = ((vv*41) >>> 10) + 5*v + 140*S - u + (I <<< FRAC)
  - v_new = v + (dv >>> DT_SHIFT)
  - du = (a*(((b*v) >>> FRAC) - u)) >>> FRAC
  - u_new = u + (du >>> DT_SHIFT)
- All v/u results, including u+d, saturate to [-2^(DW-1), 2^(DW-1)-1]; they never wrap.
- Config writes are accepted in any state and take effect for updates issued in the cycles after the write. Writes do not alter stored v/u.
- A write and a reset in the same cycle: reset wins.

Test Plan:
- Reset values: assert reset mid-sweep -> busy=0, outputs 0; a subsequent sweep with I=0 on all neurons gives upd_v=-8657 for ids 0..3 in order, spike=0, and done exactly 1 cycle after the last upd_valid.
- Strong drive: I=127 on neuron 2 only, sweep 1 -> id2 upd_v=7599 and u stays -1690; sweep 2 -> id2 spike=1 with upd_v=-8320 and u becomes -666; the other neurons are unaffected.
- Handshake: tick held high continuously -> sweeps are separated by the done cycle; tick pulses while busy produce no extra upd_valid (exactly 4 per sweep).
- Config: write c=-6400 during IDLE, then drive a spike on neuron 0 -> spike upd_v=-6400; read back via the next sweep's behaviour with I=0.
- Saturation: write c=-32000, cause a spike, then the next sweep with I=0 -> upd_v=32767 (clamped, no wrap), and the following sweep spikes.
- DT_SHIFT=1 build: I=127 from reset -> first upd_v = -8320 + (15919>>>1) = -361.
